// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues imem reads per PC address, tags returned words with their PC, queues {pc,inst} for decode.
// Latency: rvalid -> inst_valid next edge (same cycle into an empty queue when IF_BYPASS_EN is defined).
// Backpressure: credit = queue occupancy + outstanding reads < DEPTH; fetch_stall holds the PC until granted or flushed.
module if_fetch_unit #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] fetch_addr,
    output logic                  fetch_stall,
    input  logic                  flush,
    output logic                  imem_req,
    output logic [WORD_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [WORD_WIDTH-1:0] imem_rdata,
    output logic                  inst_valid,
    output logic [WORD_WIDTH-1:0] inst_data,
    output logic [WORD_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Instruction queue (pc + word) and the PC-tag FIFO for reads still in flight.
    logic [WORD_WIDTH-1:0] buf_inst [DEPTH];
    logic [WORD_WIDTH-1:0] buf_pc   [DEPTH];
    logic [WORD_WIDTH-1:0] tag_mem  [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr, tag_wp, tag_rp;
    logic [CW-1:0]         count, outst, drop;

    logic [CW:0]           occ;
    logic                  grant, rv_keep, buf_empty, byp, buf_push, buf_pop;

    // Popped entries still count this cycle, so a freed slot is only reused next cycle.
    assign occ         = {1'b0, count} + {1'b0, outst};
    assign imem_req    = !rst && !flush && (occ < (CW+1)'(DEPTH));
    assign imem_addr   = fetch_addr;
    assign grant       = imem_req && imem_gnt;
    assign fetch_stall = rst || (!grant && !flush);

    // Returns arriving while drop is non-zero belong to fetches cancelled by an earlier jump.
    assign rv_keep   = imem_rvalid && (drop == '0);
    assign buf_empty = (count == '0);

`ifdef IF_BYPASS_EN
    assign byp = !rst && buf_empty && rv_keep && !flush;
`else
    assign byp = 1'b0;
`endif

    // A bypassed word that decode takes immediately never enters the queue.
    assign buf_push = rv_keep && !flush && !(byp && inst_ready);
    assign buf_pop  = !buf_empty && inst_ready && !flush;

    // Head presentation: queued entry first, else the bypassed return, else zeros.
    always_comb begin
        inst_valid = !buf_empty || byp;
        inst_data  = '0;
        inst_pc    = '0;
        if (!buf_empty) begin
            inst_data = buf_inst[rd_ptr];
            inst_pc   = buf_pc[rd_ptr];
        end else if (byp) begin
            inst_data = imem_rdata;
            inst_pc   = tag_mem[tag_rp];
        end
    end

    // Pointers and counters; a flush empties both FIFOs and turns in-flight reads into drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            tag_wp <= '0;
            tag_rp <= '0;
            count  <= '0;
            outst  <= '0;
            drop   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            tag_wp <= '0;
            tag_rp <= '0;
            count  <= '0;
            outst  <= '0;
            drop   <= drop + outst - CW'(imem_rvalid);
        end else begin
            if (grant)    tag_wp <= tag_wp + 1'b1;
            if (rv_keep)  tag_rp <= tag_rp + 1'b1;
            if (buf_push) wr_ptr <= wr_ptr + 1'b1;
            if (buf_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(buf_push) - CW'(buf_pop);
            outst <= outst + CW'(grant) - CW'(rv_keep);
            if (imem_rvalid && !rv_keep) drop <= drop - 1'b1;
        end
    end

    // Storage arrays need no reset; validity is carried by the pointers and counters.
    always_ff @(posedge clk) begin
        if (grant)
            tag_mem[tag_wp] <= fetch_addr;
        if (buf_push) begin
            buf_inst[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]   <= tag_mem[tag_rp];
        end
    end

    // Memory must never return data nobody asked for.
    a_rvalid_expected : assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && outst == '0 && drop == '0));

endmodule
